// File: rtl/key_event_tx_ctrl_pkg.sv
// Shared definitions for the key event framing path: FSM encodings, key event layout, defaults.
package key_event_tx_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [1:0] S_SUM  = 2'd3;

  localparam int unsigned KEY_COUNT = 103;
  localparam int unsigned KEY_IDX_W = $clog2(KEY_COUNT);
  localparam int unsigned BYTE_W    = 8;

  // All-ones index is outside the key range and marks a heartbeat frame.
  localparam logic [KEY_IDX_W-1:0] HB_INDEX = 7'h7F;
  localparam logic [BYTE_W-1:0]    DEFAULT_HEADER = 8'hA5;

  typedef struct packed {
    logic                 pressed;
    logic [KEY_IDX_W-1:0] index;
  } key_event_t;

  // Third byte of every frame.
  function automatic logic [BYTE_W-1:0] frame_checksum(input logic [BYTE_W-1:0] hdr,
                                                       input logic [BYTE_W-1:0] pay);
    return hdr ^ pay;
  endfunction

endpackage

// File: rtl/key_event_tx_ctrl_event_fifo.sv
// First-word-fall-through event buffer; full/empty derive from the level count.
module event_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_pop;
  logic             do_push;

  // A push into a full buffer only lands when a pop frees the slot in the same cycle.
  assign do_pop  = pop_i && (level_q != '0);
  assign do_push = push_i && ((level_q != LVL_W'(DEPTH)) || do_pop);

  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage array, no reset needed since the level gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      level_q <= level_q + LVL_W'(1);
      else if (do_pop && !do_push) level_q <= level_q - LVL_W'(1);
    end
  end

endmodule

// File: rtl/key_event_tx_ctrl.sv
// Frames buffered key events (and idle heartbeats) as HEADER/payload/checksum bytes for the host link.
module key_event_tx_ctrl
  import key_event_tx_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  HEADER     = DEFAULT_HEADER,
  parameter int unsigned HB_CYCLES  = 1000000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          on_event_i,
  input  logic [7:0]                    key_event_i,
  output logic [7:0]                    tx_data_o,
  output logic                          tx_valid_o,
  input  logic                          tx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic                          busy_o
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned HB_W  = $clog2(HB_CYCLES);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  key_event_t       pay_q, pay_d;
  logic [HB_W-1:0]  hb_q, hb_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;

  logic             fifo_pop;
  logic [7:0]       fifo_dout;
  logic [LVL_W-1:0] fifo_level;
  logic             fifo_full;
  logic             fifo_empty;
  logic             hs;

  event_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (on_event_i),
    .din_i   (key_event_i),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .level_o (fifo_level)
  );

  assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_level == '0);
  assign hs         = tx_valid_q && tx_ready_i;

  // Frame sequencing, heartbeat timing and overflow tracking.
  always_comb begin
    state_d    = state_q;
    pay_d      = pay_q;
    hb_d       = '0;
    ovf_d      = ovf_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    fifo_pop   = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_valid_d = 1'b0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          pay_d    = key_event_t'(fifo_dout);
          state_d  = S_HDR;
        end else if ((hb_q == HB_LAST) && !on_event_i) begin
          // An event arriving this cycle holds the heartbeat off; the counter waits saturated.
          pay_d   = '{pressed: ovf_q, index: HB_INDEX};
          ovf_d   = 1'b0;
          state_d = S_HDR;
        end else begin
          hb_d = (hb_q == HB_LAST) ? hb_q : hb_q + HB_W'(1);
        end
      end
      S_HDR: begin
        // First HDR cycle loads the header byte; the byte then waits for the handshake.
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = HEADER;
        end else if (hs) begin
          tx_data_d = pay_q;
          state_d   = S_PAY;
        end
      end
      S_PAY: begin
        if (hs) begin
          tx_data_d = frame_checksum(HEADER, pay_q);
          state_d   = S_SUM;
        end
      end
      S_SUM: begin
        if (hs) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A drop wins over the heartbeat clear in the same cycle.
    if (on_event_i && fifo_full && !fifo_pop) ovf_d = 1'b1;

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pay_q      <= '0;
      hb_q       <= '0;
      ovf_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pay_q      <= pay_d;
      hb_q       <= hb_d;
      ovf_q      <= ovf_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_data_o    = tx_data_q;
  assign tx_valid_o   = tx_valid_q;
  assign fifo_level_o = fifo_level;
  assign overflow_o   = ovf_q;
  assign busy_o       = busy_q;

endmodule
